irq_ctrl: RTL

- Eight-line interrupt controller between on-chip event sources (ms tick, process timers, RS232, SPI) and the single `irq` input of the RISC5 CPU.
- Latches rising edges on `int_in` into a pending register and applies a per-line enable mask plus a global enable.
- Arbitrates by fixed priority (line 0 highest) and raises `irq`.
- Tracks one in-service interrupt from CPU `intack` to CPU `rti`; the RISC5 core has a single SPC, so there is no nesting. Memory-mapped IO device, two word registers.

---
 rtl/irq_ctrl_pkg.sv | 23 ++
 rtl/irq_ctrl_prio_enc8.sv | 26 ++
 rtl/irq_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl_pkg
// Brief    : Shared types and constants for the irq_ctrl interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_SERV = 2'd2
   } irq_state_t;

   localparam logic REG_CTRL = 1'b0;
   localparam logic REG_CUR  = 1'b1;

   localparam int GEN_BIT  = 31;
   localparam int SERV_BIT = 19;
   localparam int IRQ_BIT  = 20;

endpackage
`default_nettype wire

// File: rtl/irq_ctrl_prio_enc8.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc8
// Brief    : 8-bit priority encoder, lowest set index wins.
// Revision : 1.0 - initial release
// ============================================================================
module prio_enc8 (
   input  logic [7:0] req,
   output logic [2:0] idx,
   output logic       valid
);

   // Scanning downward lets the lowest set bit overwrite any higher one.
   always_comb begin
      idx   = 3'd0;
      valid = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (req[i]) begin
            idx   = 3'(i);
            valid = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Brief    : Eight-line edge-triggered interrupt controller for the RISC5 CPU.
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_LINES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stb,
   input  logic        we,
   input  logic        addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        ack,
   input  logic [7:0]  int_in,
   input  logic        intack,
   input  logic        rti,
   output logic        irq
);

   localparam logic [7:0] c_line_mask = 8'((16'd1 << NUM_LINES) - 16'd1);

   logic [7:0]  r_prev_in;
   logic [7:0]  r_pending;
   logic [7:0]  r_enable;
   logic        r_gen;
   logic [2:0]  r_cur;
   logic        r_irq;
   irq_state_t  r_state;

   logic [7:0]  w_ev;
   logic        w_wr_ctrl;
   logic        w_wr_cur;
   logic [7:0]  w_clr;
   logic [7:0]  w_sw_set;
   logic [7:0]  w_elig;
   logic [2:0]  w_sel;
   logic        w_any;
   logic        w_accept;
   logic [7:0]  w_pend_nxt;
   irq_state_t  w_state_nxt;
   logic        w_irq_nxt;
   logic [2:0]  w_cur_nxt;
   logic [31:0] w_rdata;

   assign w_ev      = int_in & ~r_prev_in & c_line_mask;
   assign w_wr_ctrl = stb & we & (addr == REG_CTRL);
   assign w_wr_cur  = stb & we & (addr == REG_CUR);
   assign w_clr     = w_wr_cur ? data_in[7:0]  : 8'h00;
   assign w_sw_set  = w_wr_cur ? data_in[15:8] : 8'h00;
   assign w_elig    = r_pending & r_enable & {8{r_gen}};
   assign w_accept  = (r_state == S_REQ) & intack & w_any;

   prio_enc8 u_prio (
      .req   (w_elig),
      .idx   (w_sel),
      .valid (w_any)
   );

   // Set has priority over clear so a coincident event is never dropped.
   always_comb begin
      w_pend_nxt = r_pending;
      for (int i = 0; i < 8; i++) begin
         if (w_ev[i] | w_sw_set[i]) begin
            w_pend_nxt[i] = 1'b1;
         end else if (w_clr[i] | (w_accept & (w_sel == 3'(i)))) begin
            w_pend_nxt[i] = 1'b0;
         end
      end
      w_pend_nxt = w_pend_nxt & c_line_mask;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_irq_nxt   = r_irq;
      w_cur_nxt   = r_cur;
      case (r_state)
         S_IDLE: begin
            w_irq_nxt = 1'b0;
            if (w_any) begin
               w_irq_nxt   = 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (w_accept) begin
               w_cur_nxt   = w_sel;
               w_irq_nxt   = 1'b0;
               w_state_nxt = S_SERV;
            end else if (!w_any) begin
               w_irq_nxt   = 1'b0;
               w_state_nxt = S_IDLE;
            end else begin
               w_irq_nxt   = 1'b1;
            end
         end
         S_SERV: begin
            w_irq_nxt = 1'b0;
            if (rti) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_irq_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev_in <= 8'h00;
         r_pending <= 8'h00;
         r_enable  <= 8'h00;
         r_gen     <= 1'b0;
         r_cur     <= 3'd0;
         r_irq     <= 1'b0;
         r_state   <= S_IDLE;
      end else begin
         r_prev_in <= int_in;
         r_pending <= w_pend_nxt;
         if (w_wr_ctrl) begin
            r_enable <= data_in[7:0] & c_line_mask;
            r_gen    <= data_in[GEN_BIT];
         end
         r_cur     <= w_cur_nxt;
         r_irq     <= w_irq_nxt;
         r_state   <= w_state_nxt;
      end
   end

   always_comb begin
      w_rdata = 32'h0;
      if (stb) begin
         if (addr == REG_CTRL) begin
            w_rdata[7:0]    = r_pending;
            w_rdata[15:8]   = r_enable;
            w_rdata[18:16]  = r_cur;
            w_rdata[SERV_BIT] = (r_state == S_SERV);
            w_rdata[IRQ_BIT]  = r_irq;
            w_rdata[GEN_BIT]  = r_gen;
         end else begin
            w_rdata[2:0]    = r_cur;
            w_rdata[31]     = (r_state == S_SERV);
         end
      end
   end

   assign data_out = w_rdata;
   assign ack      = stb;
   assign irq      = r_irq;

endmodule
`default_nettype wire
